quad_encoder_gen: RTL

//  Parametrised quadrature-encoder emulator. Turns clockwise/counter-clockwise requests into a

---
 rtl/quad_encoder_gen_pkg.sv | 44 ++++
 rtl/quad_encoder_gen_if.sv | 24 ++
 rtl/quad_encoder_gen_prescaler.sv | 27 ++
 rtl/quad_encoder_gen.sv | 98 +++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared types and Gray-code helpers for the quadrature encoder emulator.
// Defines the command/direction enum and the CW/CCW Gray successor functions.
package quad_enc_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } quad_dir_t;

    // {A,B} states in clockwise order
    localparam logic [1:0] GRAY_S0 = 2'b00;
    localparam logic [1:0] GRAY_S1 = 2'b10;
    localparam logic [1:0] GRAY_S2 = 2'b11;
    localparam logic [1:0] GRAY_S3 = 2'b01;

    function automatic logic [1:0] gray_next_cw(input logic [1:0] ab);
        case (ab)
            GRAY_S0: gray_next_cw = GRAY_S1;
            GRAY_S1: gray_next_cw = GRAY_S2;
            GRAY_S2: gray_next_cw = GRAY_S3;
            default: gray_next_cw = GRAY_S0;
        endcase
    endfunction

    function automatic logic [1:0] gray_next_ccw(input logic [1:0] ab);
        case (ab)
            GRAY_S0: gray_next_ccw = GRAY_S3;
            GRAY_S3: gray_next_ccw = GRAY_S2;
            GRAY_S2: gray_next_ccw = GRAY_S1;
            default: gray_next_ccw = GRAY_S0;
        endcase
    endfunction

    function automatic quad_dir_t decode_cmd(input logic horario, input logic antihorario);
        if (horario && !antihorario)
            decode_cmd = DIR_CW;
        else if (antihorario && !horario)
            decode_cmd = DIR_CCW;
        else
            decode_cmd = DIR_IDLE;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Request/quadrature bundle between the direction logic and the encoder emulator.
// slave = encoder side (consumes requests), master = requester/observer side.
interface quad_encoder_gen_if #(
    parameter int POS_W = 16
);
    logic             horario;
    logic             antihorario;
    logic             A;
    logic             B;
    logic [POS_W-1:0] position;
    logic             dir;
    logic             step_pulse;
    logic             Z;

    modport master (
        output horario, antihorario,
        input  A, B, position, dir, step_pulse, Z
    );

    modport slave (
        input  horario, antihorario,
        output A, B, position, dir, step_pulse, Z
    );
endinterface

// File: rtl/quad_encoder_gen_prescaler.sv
// Step-rate prescaler: counts 0..STEP_DIV-1 while running, ticks on the terminal count.
// clear restarts the count without producing a tick on that edge.
module quad_step_prescaler #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && !clear && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!run || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: Gray A/B generation, wrapping position and step strobe.
// Optional index output Z is built only when QUAD_ENC_INDEX_EN is defined.
module quad_encoder_gen
    import quad_enc_pkg::*;
#(
    parameter int STEP_DIV = 4,
    parameter int CPR      = 1024,
    parameter int POS_W    = 16
) (
    input logic              clk,
    input logic              rst_n,
    quad_encoder_gen_if.slave enc
);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(CPR - 1);

    quad_dir_t        cmd;
    quad_dir_t        cmd_q;
    logic             run;
    logic             clear;
    logic             tick;
    logic [1:0]       ab_q;
    logic [1:0]       ab_d;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    logic             dir_q;
    logic             dir_d;
    logic             pulse_q;

    assign cmd = decode_cmd(enc.horario, enc.antihorario);
    assign run = (cmd != DIR_IDLE);
    // A direct CW<->CCW reversal restarts the step interval
    assign clear = ((cmd == DIR_CW) && (cmd_q == DIR_CCW)) ||
                   ((cmd == DIR_CCW) && (cmd_q == DIR_CW));

    quad_step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .clear(clear),
        .tick (tick)
    );

    always_comb begin
        ab_d  = ab_q;
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick) begin
            if (cmd == DIR_CW) begin
                ab_d  = gray_next_cw(ab_q);
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
                dir_d = 1'b1;
            end else begin
                ab_d  = gray_next_ccw(ab_q);
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
                dir_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q   <= DIR_IDLE;
            ab_q    <= GRAY_S0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cmd_q   <= cmd;
            ab_q    <= ab_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            pulse_q <= tick;
        end
    end

    assign enc.A          = ab_q[1];
    assign enc.B          = ab_q[0];
    assign enc.position   = pos_q;
    assign enc.dir        = dir_q;
    assign enc.step_pulse = pulse_q;

`ifdef QUAD_ENC_INDEX_EN
    logic z_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            z_q <= 1'b0;
        else
            z_q <= tick && (pos_d == '0);
    end

    assign enc.Z = z_q;
`else
    assign enc.Z = 1'b0;
`endif
endmodule
